hrm_io_bridge: RTL
==================

# hrm_io_bridge

Host-side companion to `hrmcpu` that drives the far end of the CPU's INBOX/OUTBOX ports. It turns an incoming byte stream, such as a UART receiver, into single-cycle `cpu_in_wr` pulses gated by `cpu_in_full`. It also drains the OUTBOX with `cpu_out_rd` pops into an outgoing valid/ready byte stream, such as a UART transmitter. The block sits in the top level between the serial front end and `hrmcpu`, and replaces the hand-timed pokes used in simulation.

## Interface
- `RXDEPTH_LOG2`, default 2: log2 depth of the receive FIFO (4 entries).
- `clk`  input  1  system clock; single clock domain.
- `i_rst`  input  1  synchronous, active-high reset.
- `rx_data`  input  8  byte from the serial receiver.
- `rx_valid`  input  1  one-cycle strobe; `rx_data` is valid this cycle.
- `rx_overflow`  output  1  sticky flag: a byte was dropped because the FIFO was full.
- `tx_data`  output  8  byte to the serial transmitter.
- `tx_valid`  output  1  `tx_data` is valid; held until accepted.
- `tx_ready`  input  1  transmitter accepts `tx_data` when `tx_valid & tx_ready`.
- `cpu_in_data`  output  8  to `hrmcpu.cpu_in_data`.
- `cpu_in_wr`  output  1  to `hrmcpu.cpu_in_wr`; one-cycle write pulse.
- `cpu_in_full`  input  1  from `hrmcpu.cpu_in_full`.
- `cpu_out_rd`  output  1  to `hrmcpu.cpu_out_rd`; one-cycle pop pulse.
- `cpu_out_data`  input  8  from `hrmcpu.cpu_out_data`.
- `cpu_out_empty`  input  1  from `hrmcpu.cpu_out_empty`.
- `in_count`  output  8  bytes written to INBOX, wraps modulo 256.
- `out_count`  output  8  bytes popped from OUTBOX, wraps modulo 256.

## Operation
**RX FIFO**
- Circular buffer of 2^`RXDEPTH_LOG2` bytes, with pointers one bit wider than the address.
- When `rx_valid` is high and the FIFO is not full, the byte is pushed.
- When `rx_valid` is high and the FIFO is full, the byte is dropped and `rx_overflow` sets to 1. It stays set until reset.
- A push and a pop in the same cycle are both honoured; occupancy is unchanged. A push while full is rejected even if a pop happens in the same cycle.

**INBOX writer FSM** (states IN_IDLE, IN_WRITE, IN_SETTLE)
- IN_IDLE → IN_WRITE when the FIFO is not empty and `cpu_in_full` is 0. The FIFO head is registered into `cpu_in_data` and popped.
- IN_WRITE: `cpu_in_wr`=1 for exactly this cycle. Increment `in_count`. Go to IN_SETTLE.
- IN_SETTLE: `cpu_in_wr`=0 for one cycle so `cpu_in_full` can update. Then go to IN_IDLE.
- `cpu_in_data` holds its value outside IN_WRITE.

**OUTBOX reader FSM** (states OUT_IDLE, OUT_POP, OUT_SETTLE, OUT_SEND)
- The OUTBOX is first-word-fall-through: `cpu_out_data` is valid whenever `cpu_out_empty`=0.
- OUT_IDLE → OUT_POP when `cpu_out_empty` is 0. `cpu_out_data` is latched into the tx register.
- OUT_POP: `cpu_out_rd`=1 for one cycle. Increment `out_count`. Go to OUT_SETTLE.
- OUT_SETTLE: one idle cycle for `cpu_out_empty` to update. Go to OUT_SEND.
- OUT_SEND: `tx_valid`=1. On `tx_ready`, go to OUT_IDLE.
- `tx_data` is stable while `tx_valid` is 1.

**General**
- The two directions are fully independent and may be active in the same cycle.
- Reset at any point aborts both FSMs. A pending tx byte and any FIFO contents are discarded. No pulse is emitted in the reset cycle.

## Timing
- Reset values: `cpu_in_wr`=0, `cpu_out_rd`=0, `tx_valid`=0, `tx_data`=0, `cpu_in_data`=0, `rx_overflow`=0, `in_count`=0, `out_count`=0. Both FSMs are in IDLE and the FIFO is empty.
- All outputs are registered.
- RX path latency:
  - `rx_valid` at edge N pushes at N.
  - IN_IDLE sees the non-empty FIFO in cycle N+1 and moves to IN_WRITE at edge N+1.
  - `cpu_in_wr` is high during cycle N+2 and the CPU samples it at edge N+2.
- INBOX throughput: at most one write per 3 cycles.
- `cpu_in_full` is sampled only in IN_IDLE. A full INBOX stalls the writer indefinitely with no data loss while the FIFO has room.
- OUTBOX path: `cpu_out_empty` falling before edge M gives `cpu_out_rd` high during cycle M+1 and `tx_valid` rising at edge M+2.
- OUTBOX throughput: at most one pop per 4 cycles with `tx_ready` held high.
- If `tx_ready` is low, the block holds OUT_SEND indefinitely and issues no further pops.

## Test plan
- **Reset:** assert `i_rst` for 2 cycles mid-transfer → all outputs at reset values, no `cpu_in_wr` or `cpu_out_rd` pulse, counters 0.
- **RX feed:** strobe 0x23, 0x15, 0x11, 0x22 on consecutive cycles with `cpu_in_full`=0 → four `cpu_in_wr` pulses 3 cycles apart, carrying the same data in order; `in_count`=4; `rx_overflow`=0.
- **RX backpressure/overflow:** hold `cpu_in_full`=1 and strobe 6 bytes 0x01..0x06 → no `cpu_in_wr`; FIFO keeps 0x01..0x04; `rx_overflow`=1. Release `cpu_in_full` → 0x01..0x04 written in order; `in_count`=4.
- **OUTBOX drain:** model the OUTBOX holding 0x46, 0x2A with `tx_ready`=1 → exactly two `cpu_out_rd` pulses; `tx_data` 0x46 then 0x2A; `out_count`=2; no pop once `cpu_out_empty`=1.
- **TX stall:** `tx_ready`=0 for 50 cycles with the OUTBOX non-empty → exactly one pop; `tx_valid` held with stable data; a second pop occurs only after the handshake.
- **Counter wrap/concurrency:** 257 bytes through each direction simultaneously → `in_count`=1, `out_count`=1, data order preserved in both streams.

Source files
------------

// File: rtl/hrm_io_bridge.sv
// hrm_io_bridge: host-side byte stream bridge for the hrmcpu INBOX/OUTBOX.
// RX bytes are buffered and written to INBOX; OUTBOX pops feed a tx stream.
module hrm_io_bridge #(
    parameter int RXDEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       i_rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_overflow,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] cpu_in_data,
    output logic       cpu_in_wr,
    input  logic       cpu_in_full,
    output logic       cpu_out_rd,
    input  logic [7:0] cpu_out_data,
    input  logic       cpu_out_empty,
    output logic [7:0] in_count,
    output logic [7:0] out_count
);

    localparam int DEPTH = 1 << RXDEPTH_LOG2;
    localparam logic [RXDEPTH_LOG2:0] PTR_MSB = {1'b1, {RXDEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        IN_IDLE,
        IN_WRITE,
        IN_SETTLE
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_POP,
        OUT_SETTLE,
        OUT_SEND
    } out_state_t;

    logic [7:0]              fifo_mem [DEPTH];
    logic [RXDEPTH_LOG2:0]   wr_ptr;
    logic [RXDEPTH_LOG2:0]   rd_ptr;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    fifo_push;
    logic                    in_pop;
    logic                    out_take;
    in_state_t               in_state;
    in_state_t               in_next;
    out_state_t              out_state;
    out_state_t              out_next;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = ((wr_ptr ^ rd_ptr) == PTR_MSB);
    assign fifo_push  = rx_valid & ~fifo_full;

    // Byte storage; contents are don't-care until pointers say otherwise.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr[RXDEPTH_LOG2-1:0]] <= rx_data;
        end
    end

    // FIFO pointers and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (in_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (rx_valid && fifo_full) begin
                rx_overflow <= 1'b1;
            end
        end
    end

    // INBOX writer next-state: only IN_IDLE looks at cpu_in_full.
    always_comb begin
        in_next = in_state;
        in_pop  = 1'b0;
        unique case (in_state)
            IN_IDLE: begin
                if (!fifo_empty && !cpu_in_full) begin
                    in_next = IN_WRITE;
                    in_pop  = 1'b1;
                end
            end
            IN_WRITE:  in_next = IN_SETTLE;
            IN_SETTLE: in_next = IN_IDLE;
            default:   in_next = IN_IDLE;
        endcase
    end

    // INBOX writer registers: state, write pulse, data and count.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            in_state    <= IN_IDLE;
            cpu_in_wr   <= 1'b0;
            cpu_in_data <= 8'h00;
            in_count    <= 8'h00;
        end else begin
            in_state  <= in_next;
            cpu_in_wr <= (in_next == IN_WRITE);
            if (in_pop) begin
                cpu_in_data <= fifo_mem[rd_ptr[RXDEPTH_LOG2-1:0]];
            end
            if (in_state == IN_WRITE) begin
                in_count <= in_count + 8'd1;
            end
        end
    end

    // OUTBOX reader next-state: pop, let empty settle, then hand off.
    always_comb begin
        out_next = out_state;
        out_take = 1'b0;
        unique case (out_state)
            OUT_IDLE: begin
                if (!cpu_out_empty) begin
                    out_next = OUT_POP;
                    out_take = 1'b1;
                end
            end
            OUT_POP:    out_next = OUT_SETTLE;
            OUT_SETTLE: out_next = OUT_SEND;
            OUT_SEND: begin
                if (tx_ready) begin
                    out_next = OUT_IDLE;
                end
            end
            default: out_next = OUT_IDLE;
        endcase
    end

    // OUTBOX reader registers: state, pop pulse, tx byte and count.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            out_state  <= OUT_IDLE;
            cpu_out_rd <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
            out_count  <= 8'h00;
        end else begin
            out_state  <= out_next;
            cpu_out_rd <= (out_next == OUT_POP);
            tx_valid   <= (out_next == OUT_SEND);
            if (out_take) begin
                tx_data <= cpu_out_data;
            end
            if (out_state == OUT_POP) begin
                out_count <= out_count + 8'd1;
            end
        end
    end

endmodule
